sensor_frame_gen: RTL and testbench



---
 rtl/sensor_frame_gen.sv | 110 +++++++++++
 tb/tb_sensor_frame_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_gen.sv
// sensor_frame_gen: patterned AXIS frame source with count, gap and graceful stop; FRAME_GEN_TLAST_EN adds AXIS_OUT_TLAST
module sensor_frame_gen #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   frame_size,
    input  logic [31:0]   frame_count,
    input  logic [15:0]   gap_cycles,
    output logic          busy,
    output logic [31:0]   frames_done,
    output logic          start_of_frame,
    output logic [DW-1:0] AXIS_OUT_TDATA,
    output logic          AXIS_OUT_TVALID,
`ifdef FRAME_GEN_TLAST_EN
    output logic          AXIS_OUT_TLAST,
    input  logic          AXIS_OUT_TREADY
`else
    input  logic          AXIS_OUT_TREADY
`endif
);
    localparam int BPB   = DW / 8;
    localparam int LANES = DW / 32;
    typedef enum logic [1:0] {IDLE, SOF, DATA, GAP} state_t;
    state_t      state_q, state_d;
    logic [31:0] fsize_q, fsize_d, fcount_q, fcount_d, frames_done_q, frames_done_d, idx_q, idx_d;
    logic [15:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic        stop_q, stop_d;
    logic [31:0] cpf_raw, cpf;
    logic        hs, last_beat, stop_eff;
    assign cpf_raw         = fsize_q / BPB;
    assign cpf             = (cpf_raw == '0) ? 32'd1 : cpf_raw;
    assign last_beat       = idx_q == cpf - 32'd1;
    assign hs              = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
    assign stop_eff        = stop_q || stop;
    assign busy            = state_q != IDLE;
    assign start_of_frame  = state_q == SOF;
    assign AXIS_OUT_TVALID = state_q == DATA;
    assign frames_done     = frames_done_q;
`ifdef FRAME_GEN_TLAST_EN
    assign AXIS_OUT_TLAST  = AXIS_OUT_TVALID && last_beat;
`endif
    always_comb begin
        state_d       = state_q;
        fsize_d       = fsize_q;
        fcount_d      = fcount_q;
        gap_d         = gap_q;
        frames_done_d = frames_done_q;
        idx_d         = idx_q;
        gap_cnt_d     = gap_cnt_q;
        stop_d        = stop_q || (busy && stop);
        case (state_q)
            IDLE: if (start) begin
                state_d       = SOF;
                fsize_d       = frame_size;
                fcount_d      = frame_count;
                gap_d         = gap_cycles;
                frames_done_d = '0;
                stop_d        = 1'b0;
            end
            SOF: begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (hs) begin
                idx_d = idx_q + 32'd1;
                if (last_beat) begin
                    frames_done_d = frames_done_q + 32'd1;
                    gap_cnt_d     = '0;
                    state_d       = (stop_eff || (fcount_q != '0 && frames_done_d == fcount_q)) ? IDLE :
                                    (gap_q == '0) ? SOF : GAP;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 16'd1;
                state_d   = stop_eff ? IDLE : (gap_cnt_q == gap_q - 16'd1) ? SOF : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    // Lane i carries the running 32-bit word count from frame start
    always_comb begin
        AXIS_OUT_TDATA = '0;
        for (int i = 0; i < LANES; i++)
            AXIS_OUT_TDATA[i*32 +: 32] = AXIS_OUT_TVALID ? idx_q * LANES + 32'(i) : 32'd0;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            fsize_q       <= '0;
            fcount_q      <= '0;
            gap_q         <= '0;
            frames_done_q <= '0;
            idx_q         <= '0;
            gap_cnt_q     <= '0;
            stop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fsize_q       <= fsize_d;
            fcount_q      <= fcount_d;
            gap_q         <= gap_d;
            frames_done_q <= frames_done_d;
            idx_q         <= idx_d;
            gap_cnt_q     <= gap_cnt_d;
            stop_q        <= stop_d;
        end
    end
endmodule

// File: tb/tb_sensor_frame_gen.sv
// tb_sensor_frame_gen: table-driven runs with a beat scoreboard plus reset/stop corner sequences
module tb_sensor_frame_gen;
    localparam int DW = 512;
    typedef struct {
        int fsize; int fcount; int gap; bit rnd; int stop_sof; bit poke;
        int exp_frames; int exp_sof; int spacing;
    } vec_t;
    typedef struct { logic [DW-1:0] d; logic l; } beat_t;
    logic          clk = 0, resetn = 0, start = 0, stop = 0, tready = 1;
    logic [31:0]   frame_size = 0, frame_count = 0;
    logic [15:0]   gap_cycles = 0;
    logic          busy, sof, valid, tlast;
    logic [31:0]   frames_done;
    logic [DW-1:0] tdata, prev_data;
    int checks = 0, errors = 0, cyc = 0;
    int sof_count = 0, hs_count = 0, sof_first = 0, sof_second = 0, last_hs_cyc = 0;
    bit rnd_ready = 0, prev_stall = 0;
    beat_t sb[$];
    vec_t  vecs[7];

    sensor_frame_gen #(.DW(DW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .frame_size(frame_size), .frame_count(frame_count), .gap_cycles(gap_cycles),
        .busy(busy), .frames_done(frames_done), .start_of_frame(sof),
        .AXIS_OUT_TDATA(tdata), .AXIS_OUT_TVALID(valid),
`ifdef FRAME_GEN_TLAST_EN
        .AXIS_OUT_TLAST(tlast),
`endif
        .AXIS_OUT_TREADY(tready)
    );
`ifndef FRAME_GEN_TLAST_EN
    assign tlast = 1'b0;
`endif

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(posedge clk); #1;
        tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int b);
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = 32'(b * (DW/32) + i);
        return r;
    endfunction

    task automatic push_frames(input int fsize, input int frames);
        int cpf;
        cpf = fsize / (DW/8);
        if (cpf == 0) cpf = 1;
        for (int f = 0; f < frames; f++)
            for (int b = 0; b < cpf; b++) sb.push_back('{d: beat_data(b), l: (b == cpf - 1)});
    endtask

    task automatic launch(input int fsize, input int fcount, input int gap);
        sof_count = 0; hs_count = 0;
        @(posedge clk); #1;
        frame_size = 32'(fsize); frame_count = 32'(fcount); gap_cycles = 16'(gap); start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    // Monitor: pops the scoreboard on each handshake and checks holds across stalls
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (resetn) begin
            if (sof) begin
                if (sof_count == 0) sof_first = cyc;
                else if (sof_count == 1) sof_second = cyc;
                sof_count++;
            end
            if (prev_stall) begin
                checks++;
                if (!valid || tdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%0b lane0=%0d required valid=1 lane0=%0d", valid, tdata[31:0], prev_data[31:0]);
                end
            end
            if (valid && tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_extra got lane0=%0d required no beat", tdata[31:0]);
                end else begin
                    e = sb.pop_front();
                    if (tdata !== e.d
`ifdef FRAME_GEN_TLAST_EN
                        || tlast !== e.l
`endif
                       ) begin
                        errors++;
                        $display("FAIL beat_data got %h last=%0b required %h last=%0b", tdata, tlast, e.d, e.l);
                    end
                end
                hs_count++;
                last_hs_cyc = cyc;
            end
            prev_stall = valid && !tready;
            prev_data  = tdata;
        end else prev_stall = 0;
    end

    task automatic run_vec(input vec_t v);
        int budget, start_cyc, cpf;
        bit stop_sent, poke_sent;
        cpf = v.fsize / (DW/8);
        if (cpf == 0) cpf = 1;
        rnd_ready = v.rnd;
        push_frames(v.fsize, v.exp_frames);
        start_cyc = cyc + 1;
        launch(v.fsize, v.fcount, v.gap);
        budget = 0; stop_sent = 0; poke_sent = 0;
        while (busy && budget < 3000) begin
            stop = 0; start = 0;
            if (v.stop_sof != 0 && !stop_sent && sof_count >= v.stop_sof) begin stop = 1; stop_sent = 1; end
            if (v.poke && !poke_sent && sof_count >= 1) begin
                start = 1; frame_size = 32'd1024; frame_count = 32'd5; poke_sent = 1;
            end
            @(posedge clk); #1;
            budget++;
        end
        stop = 0; start = 0;
        check("run_timeout", budget < 3000, 1);
        check("busy_drop_cycle", cyc, last_hs_cyc + 1);
        rnd_ready = 0;
        repeat (10) @(negedge clk);
        check("frames_done", frames_done, v.exp_frames);
        check("handshakes", hs_count, v.exp_frames * cpf);
        check("sof_count", sof_count, v.exp_sof);
        check("first_sof_latency", sof_first - start_cyc, 1);
        if (v.spacing != 0) check("sof_spacing", sof_second - sof_first, v.spacing);
        check("scoreboard_empty", sb.size(), 0);
        check("idle_valid", valid, 0);
    endtask

    initial begin
        int budget;
        vecs[0] = '{1024, 2, 0, 0, 0, 0, 2, 2, 17};
        vecs[1] = '{1024, 2, 0, 1, 0, 0, 2, 2, 0};
        vecs[2] = '{128,  0, 5, 0, 3, 0, 3, 3, 8};
        vecs[3] = '{10,   1, 0, 0, 0, 0, 1, 1, 0};
        vecs[4] = '{200,  3, 2, 1, 0, 0, 3, 3, 0};
        vecs[5] = '{127,  2, 1, 0, 0, 0, 2, 2, 3};
        vecs[6] = '{128,  2, 0, 0, 0, 1, 2, 2, 3};
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_sof", sof, 0);
        check("rst_frames_done", frames_done, 0);
        check("rst_tdata_zero", tdata == '0, 1);
        @(posedge clk); #1;
        resetn = 1;
        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Reset at beat 7 of a frame, then restart from word 0
        push_frames(1024, 1);
        launch(1024, 0, 0);
        budget = 0;
        while (hs_count < 7 && budget < 200) begin @(posedge clk); #1; budget++; end
        check("reset_wait_timeout", budget < 200, 1);
        resetn = 0;
        #1;
        check("mid_rst_valid", valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sof", sof, 0);
        check("mid_rst_frames_done", frames_done, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        run_vec('{1024, 1, 0, 0, 0, 0, 1, 1, 0});

        // Stop during the gap: no further SOF
        push_frames(128, 1);
        launch(128, 0, 20);
        budget = 0;
        while (frames_done != 1 && budget < 200) begin @(posedge clk); #1; budget++; end
        check("gap_wait_timeout", budget < 200, 1);
        stop = 1;
        @(posedge clk); #1;
        stop = 0;
        check("gap_stop_busy", busy, 0);
        repeat (30) @(negedge clk);
        check("gap_stop_sof_count", sof_count, 1);
        check("gap_stop_frames", frames_done, 1);
        check("gap_stop_handshakes", hs_count, 2);
        check("gap_stop_sb_empty", sb.size(), 0);

        // Stop while idle is ignored by the next run
        @(posedge clk); #1;
        stop = 1;
        @(posedge clk); #1;
        stop = 0;
        run_vec('{64, 2, 0, 0, 0, 0, 2, 2, 2});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
